// File: rtl/wb_stopwatch_pkg.sv
// wb_stopwatch_pkg: register map, bit indices, bus FSM encoding and BCD digit limits for the stopwatch slave.
package wb_stopwatch_pkg;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_TIME   = 2'd1;
    localparam logic [1:0] REG_LOAD   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;
    localparam int CTRL_RUN    = 0;
    localparam int CTRL_CLR    = 1;
    localparam int ST_RUNNING  = 0;
    localparam int ST_WRAP     = 1;
    localparam int ST_LOAD_ERR = 2;
    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;
    typedef enum logic {S_IDLE, S_ACK} bus_state_t;
    function automatic logic bcd_valid(input logic [15:0] v);
        return v[3:0] <= UNITS_MAX && v[7:4] <= TENS_MAX && v[11:8] <= UNITS_MAX && v[15:12] <= TENS_MAX;
    endfunction
endpackage

// File: rtl/bcd_mmss_counter.sv
// bcd_mmss_counter: mm:ss BCD digit registers with clear > load > increment priority and a 59:59 wrap pulse.
module bcd_mmss_counter
    import wb_stopwatch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_value,
    output logic [3:0]  sec1,
    output logic [3:0]  sec2,
    output logic [3:0]  min1,
    output logic [3:0]  min2,
    output logic        wrap
);
    logic s1_c, s2_c, m1_c;
    assign s1_c = sec1 == UNITS_MAX;
    assign s2_c = s1_c && sec2 == TENS_MAX;
    assign m1_c = s2_c && min1 == UNITS_MAX;
    assign wrap = inc && !clr && m1_c && min2 == TENS_MAX;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {min2, min1, sec2, sec1} <= '0;
        end else if (clr) begin
            {min2, min1, sec2, sec1} <= '0;
        end else if (load) begin
            {min2, min1, sec2, sec1} <= load_value;
        end else if (inc) begin
            sec1 <= s1_c ? 4'd0 : sec1 + 4'd1;
            if (s1_c) sec2 <= s2_c ? 4'd0 : sec2 + 4'd1;
            if (s2_c) min1 <= m1_c ? 4'd0 : min1 + 4'd1;
            if (m1_c) min2 <= min2 == TENS_MAX ? 4'd0 : min2 + 4'd1;
        end
    end
endmodule

// File: rtl/wb_slave_stopwatch.sv
// wb_slave_stopwatch: Wishbone classic slave exposing a run/clear/load mm:ss stopwatch.
module wb_slave_stopwatch
    import wb_stopwatch_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_data,
    input  logic [3:0]  wb_sel,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    output logic [31:0] wb_data_read,
    output logic        wb_ack,
    input  logic        tick,
    output logic [3:0]  sec1,
    output logic [3:0]  sec2,
    output logic [3:0]  min1,
    output logic [3:0]  min2,
    output logic        running
);
    bus_state_t  state;
    logic        hit, acc, wr, ctrl_wr, status_wr, load_wr, load_ok, clr;
    logic        run, wrap_flag, load_err, wrap_pulse;
    logic [1:0]  reg_sel;
    logic [31:0] rdata;
    logic        unused_bits;
    assign unused_bits = ^{wb_addr[1:0], wb_sel[3:2], wb_data[31:16]};
    assign reg_sel   = wb_addr[3:2];
    assign hit       = wb_addr[31:4] == BASE_ADDR[31:4];
    assign acc       = state == S_IDLE && wb_cyc && wb_stb;
    assign wr        = acc && wb_we && hit;
    assign ctrl_wr   = wr && reg_sel == REG_CTRL && wb_sel[0];
    assign status_wr = wr && reg_sel == REG_STATUS && wb_sel[0];
    assign load_wr   = wr && reg_sel == REG_LOAD && wb_sel[1:0] == 2'b11;
    assign load_ok   = load_wr && !run && bcd_valid(wb_data[15:0]);
    assign clr       = ctrl_wr && wb_data[CTRL_CLR];
    assign running   = run;
    always_comb begin
        rdata = !hit || wb_we ? 32'd0 :
                reg_sel == REG_CTRL   ? 32'(run) :
                reg_sel == REG_TIME   ? {16'd0, min2, min1, sec2, sec1} :
                reg_sel == REG_STATUS ? {29'd0, load_err, wrap_flag, run} : 32'd0;
    end
    // Status flags are sticky; a same-edge set event overrides the W1C.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            wb_ack       <= 1'b0;
            wb_data_read <= '0;
            run          <= 1'b0;
            wrap_flag    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            state        <= acc ? S_ACK : S_IDLE;
            wb_ack       <= acc;
            wb_data_read <= acc ? rdata : 32'd0;
            if (ctrl_wr) run <= wb_data[CTRL_RUN];
            wrap_flag    <= wrap_pulse || (wrap_flag && !(status_wr && wb_data[ST_WRAP]));
            load_err     <= (load_wr && !load_ok) || (load_err && !(status_wr && wb_data[ST_LOAD_ERR]));
        end
    end
    bcd_mmss_counter u_counter (
        .clk        (clk),
        .rst        (rst),
        .inc        (tick && run),
        .clr        (clr),
        .load       (load_ok),
        .load_value (wb_data[15:0]),
        .sec1       (sec1),
        .sec2       (sec2),
        .min1       (min1),
        .min2       (min2),
        .wrap       (wrap_pulse)
    );
endmodule

// File: doc/wb_slave_stopwatch.md
WB_SLAVE_STOPWATCH -- requirements
Module: wb_slave_stopwatch

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: bus base address; the block decodes wb_addr[31:4] == BASE_ADDR[31:4].
REQ-002 clk  in  1  single clock; all logic on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 wb_addr  in  32  byte address; wb_addr[3:2] selects the register.
REQ-005 wb_data  in  32  write data.
REQ-006 wb_sel  in  4  byte lanes.
REQ-007 wb_cyc, wb_stb, wb_we  in  1 each  Wishbone classic cycle, strobe and write enable.
REQ-008 wb_data_read  out  32  read data.
REQ-009 wb_ack  out  1  transfer acknowledge.
REQ-010 tick  in  1  1 Hz single-cycle enable pulse from the upstream divider.
REQ-011 sec1, sec2, min1, min2  out  4 each  BCD digits driven to the segment decoders.
REQ-012 running  out  1  mirror of CTRL.run.

Function
REQ-013 Register map offsets:
- 0x0 CTRL: bit0 run (RW); bit1 clear (write-1 pulse, reads 0).
- 0x4 TIME: RO, {16'b0, min2, min1, sec2, sec1}.
- 0x8 LOAD: WO, same layout as TIME, reads 0.
- 0xC STATUS: bit0 running (RO); bit1 wrap (sticky, W1C); bit2 load_err (sticky, W1C).
REQ-014 Bus FSM states:
- IDLE: when wb_cyc&wb_stb, go to ACK.
- ACK: wb_ack=1 for exactly one cycle, then return to IDLE.
- A held strobe therefore completes back-to-back transfers, each taking 2 cycles.
REQ-015 Write side effects commit on the IDLE->ACK edge; read data is registered on the same edge and held while wb_ack=1; wb_data_read=0 whenever wb_ack=0.
REQ-016 Byte lanes: CTRL and STATUS writes require wb_sel[0]; LOAD writes require wb_sel[1:0]==2'b11; otherwise the write is acknowledged and ignored.
REQ-017 An address outside the block, or a write to TIME: acknowledged, write ignored, read returns 0.
REQ-018 Counting: a tick while run=1 advances the time by one second in BCD:
- sec1 counts 0..9; sec2 counts 0..5 and steps on sec1 9->0;
- min1 counts 0..9 and steps on the seconds 59->00; min2 counts 0..5.
REQ-019 Wrap: 59:59 + tick -> 00:00, wrap set to 1, and counting continues.
REQ-020 Digits update the cycle after the tick; running updates the cycle after the CTRL write.
REQ-021 Simultaneous tick and CTRL write: the pre-write run value decides whether that tick counts.
REQ-022 Clear: sets all digits to 0 and leaves run unchanged; clear wins over a simultaneous tick.
REQ-023 LOAD while run=1: ignored and sets load_err.
REQ-024 LOAD with any digit out of range (sec1>9, sec2>5, min1>9, min2>5): ignored, load_err set, digits unchanged.
REQ-025 W1C write together with a same-cycle set event: set wins.

Reset
REQ-026 While rst=0, asynchronously force:
- wb_ack=0, wb_data_read=0, FSM=IDLE;
- run=0, wrap=0, load_err=0;
- all digits 0, running=0.
REQ-027 Reset mid-transfer aborts it; no ack is issued for the aborted transfer.
REQ-028 The first transfer is accepted in the first cycle after rst is released.

Structure
REQ-029 Package wb_stopwatch_pkg holds:
- register offsets and CTRL/STATUS bit indices;
- the FSM state encoding;
- digit limits (9, 5).
REQ-030 Sub-module bcd_mmss_counter holds the four digit registers:
- inputs: inc, clr, load, load_value;
- outputs: digits and a wrap pulse.
- The bus logic stays in wb_slave_stopwatch.

Verification
REQ-031 Scenario: release reset; read TIME, CTRL, STATUS -> all 0; wb_ack is high exactly 1 cycle per access.
REQ-032 Scenario: write LOAD=0x5958, then CTRL=1, then 2 ticks:
- after tick 1: TIME=0x5959;
- after tick 2: TIME=0x0000, STATUS=0x3.
- Then write STATUS=0x2 -> STATUS=0x1.
REQ-033 Scenario: write LOAD=0x0A00 while stopped -> TIME unchanged, STATUS bit2=1. Then CTRL=1 and LOAD=0x0100 -> ignored, bit2 stays 1.
REQ-034 Scenario: run=1, TIME=0x0009; CTRL write 0x3 in the same cycle as a tick -> TIME=0x0000, running=1.
REQ-035 Scenario: wb_stb held 6 cycles on a TIME read -> 3 ack pulses. Assert rst during a pending ACK -> no ack, all registers 0.
